// File: rtl/actn_collector_pkg.sv
// actn_collector_pkg: shared defaults and lane-slicing helpers for the activation collector
package actn_collector_pkg;
  localparam int FI_DEF = 4;
  localparam int Z_DEF = 8;
  localparam int N_DEF = 8;
  localparam int WIDTH_DEF = 16;
  localparam int LANES_PER_BEAT = Z_DEF / FI_DEF;
  localparam int WORDS_PER_LAYER = N_DEF / Z_DEF;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
  localparam int BEAT_CNT_W = clog2_min1(FI_DEF);
  localparam int ADDR_W = clog2_min1(WORDS_PER_LAYER);
endpackage

// File: rtl/actn_collector_if.sv
// actn_collector_if: beat input and word output handshakes of the activation collector
interface actn_collector_if
  import actn_collector_pkg::*;
#(
  parameter int width = WIDTH_DEF,
  parameter int z = Z_DEF,
  parameter int fi = FI_DEF,
  parameter int addr_w = ADDR_W
);
  logic in_valid;
  logic in_ready;
  logic [width*z/fi-1:0] sigmoid_package;
  logic [width*z/fi-1:0] sp_package;
  logic out_valid;
  logic out_ready;
  logic [width*z-1:0] act_word;
  logic [width*z-1:0] sp_word;
  logic [addr_w-1:0] word_addr;
  logic layer_done;
  modport master (
    output in_valid, sigmoid_package, sp_package, out_ready,
    input in_ready, out_valid, act_word, sp_word, word_addr, layer_done
  );
  modport slave (
    input in_valid, sigmoid_package, sp_package, out_ready,
    output in_ready, out_valid, act_word, sp_word, word_addr, layer_done
  );
endinterface

// File: rtl/actn_lane_buffer.sv
// actn_lane_buffer: z-lane assembly register written one beat slice at a time
module actn_lane_buffer
  import actn_collector_pkg::*;
#(
  parameter int width = WIDTH_DEF,
  parameter int z = Z_DEF,
  parameter int fi = FI_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic we,
  input  logic [clog2_min1(fi)-1:0] beat,
  input  logic [width*z/fi-1:0] din,
  output logic [width*z-1:0] merged
);
  localparam int slice_w = width * z / fi;
  localparam int bw = clog2_min1(fi);
  logic [width*z-1:0] buffer;
  for (genvar g = 0; g < fi; g++) begin : g_slice
    assign merged[g*slice_w +: slice_w] = (we && beat == bw'(g)) ? din : buffer[g*slice_w +: slice_w];
  end
  // merged already carries the incoming beat, so storing it updates just that slice
  always_ff @(posedge clk) begin
    if (!reset_n) buffer <= '0;
    else if (we) buffer <= merged;
  end
endmodule

// File: rtl/actn_collector.sv
// actn_collector: gathers fi sigmoid/sigmoid-prime beats into addressed z-lane words
module actn_collector
  import actn_collector_pkg::*;
#(
  parameter int fi = FI_DEF,
  parameter int z = Z_DEF,
  parameter int n = N_DEF,
  parameter int width = WIDTH_DEF
) (
  input logic clk,
  input logic reset_n,
  actn_collector_if.slave bus
);
  localparam int words_per_layer = n / z;
  localparam int beat_cnt_w = clog2_min1(fi);
  localparam int addr_w = clog2_min1(words_per_layer);
  logic [beat_cnt_w-1:0] beat_cnt;
  logic [addr_w-1:0] word_cnt;
  logic last_beat;
  logic last_word;
  logic accept;
  logic complete;
  logic [width*z-1:0] act_next;
  logic [width*z-1:0] sp_next;
  assign last_beat = beat_cnt == beat_cnt_w'(fi - 1);
  assign last_word = word_cnt == addr_w'(words_per_layer - 1);
  assign bus.in_ready = !(last_beat && bus.out_valid && !bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign complete = accept && last_beat;
  actn_lane_buffer #(.width(width), .z(z), .fi(fi)) u_act (
    .clk(clk), .reset_n(reset_n), .we(accept), .beat(beat_cnt),
    .din(bus.sigmoid_package), .merged(act_next)
  );
  actn_lane_buffer #(.width(width), .z(z), .fi(fi)) u_sp (
    .clk(clk), .reset_n(reset_n), .we(accept), .beat(beat_cnt),
    .din(bus.sp_package), .merged(sp_next)
  );
  // beat/word counters and the output register; a completing word overrides a drain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      word_cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.layer_done <= 1'b0;
      bus.word_addr <= '0;
      bus.act_word <= '0;
      bus.sp_word <= '0;
    end else begin
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + beat_cnt_w'(1);
      if (complete) begin
        bus.out_valid <= 1'b1;
        bus.act_word <= act_next;
        bus.sp_word <= sp_next;
        bus.word_addr <= word_cnt;
        bus.layer_done <= last_word;
        word_cnt <= last_word ? '0 : word_cnt + addr_w'(1);
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_actn_collector.sv
// tb_actn_collector: table-driven and scoreboard checks of the activation collector
module tb_actn_collector;
  localparam int FI = 4;
  localparam int Z = 8;
  localparam int N = 16;
  localparam int W = 16;
  localparam int LPB = Z / FI;
  localparam int WPL = N / Z;
  localparam logic [127:0] C0 = 128'h0301_0300_0201_0200_0101_0100_0001_0000;
  localparam logic [127:0] SPX = {8{16'h5A5A}};

  typedef struct {
    logic [127:0] act;
    logic [127:0] sp;
    logic [0:0] addr;
    logic done;
  } exp_t;

  typedef struct packed {
    logic v;
    logic r;
    logic exp_rdy;
    logic exp_ov;
  } bp_vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  actn_collector_if #(.width(W), .z(Z), .fi(FI), .addr_w(1)) bus();
  actn_collector #(.fi(FI), .z(Z), .n(N), .width(W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_pop = 0;
  int n_done = 0;
  int s = 0;
  logic rdy_s, ov_s;
  exp_t q[$];
  logic [127:0] m_act, m_sp;
  int mb = 0;
  int mw = 0;
  bp_vec_t bp[13];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic r);
    logic acc;
    bus.in_valid = v;
    bus.out_ready = r;
    for (int i = 0; i < LPB; i++) begin
      logic [15:0] val;
      val = 16'(16'h0100 * (s % 8) + i);
      bus.sigmoid_package[i*16 +: 16] = val;
      bus.sp_package[i*16 +: 16] = val ^ 16'h5A5A;
    end
    @(negedge clk);
    rdy_s = bus.in_ready;
    ov_s = bus.out_valid;
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (acc) s++;
  endtask

  // scoreboard: independent beat model pushes words, output handshakes pop them
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      mb = 0;
      mw = 0;
      m_act = '0;
      m_sp = '0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got out_valid=1 expected no pending word");
        end else begin
          check("word_act", bus.act_word, q[0].act);
          check("word_sp", bus.sp_word, q[0].sp);
          check("word_addr", 128'(bus.word_addr), 128'(q[0].addr));
          check("layer_done", 128'(bus.layer_done), 128'(q[0].done));
          if (bus.out_ready) begin
            if (q[0].done) n_done++;
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < LPB; i++) begin
          m_act[(mb*LPB+i)*16 +: 16] = bus.sigmoid_package[i*16 +: 16];
          m_sp[(mb*LPB+i)*16 +: 16] = bus.sp_package[i*16 +: 16];
        end
        if (mb == FI - 1) begin
          q.push_back('{act: m_act, sp: m_sp, addr: 1'(mw), done: (mw == WPL - 1)});
          mw = (mw == WPL - 1) ? 0 : mw + 1;
          mb = 0;
        end else begin
          mb++;
        end
      end
    end
  end

  initial begin
    int p0, d0;
    bp[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bp[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bp[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bp[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bp[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bp[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bp[6] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bp[7] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bp[8] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bp[9] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bp[10] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bp[11] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bp[12] = '{1'b0, 1'b1, 1'b1, 1'b0};
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.sigmoid_package = '0;
    bus.sp_package = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_word_addr", 128'(bus.word_addr), 128'(0));
    check("rst_layer_done", 128'(bus.layer_done), 128'(0));
    check("rst_act_word", bus.act_word, 128'(0));
    check("rst_sp_word", bus.sp_word, 128'(0));
    // free flow
    s = 0;
    repeat (4) step(1'b1, 1'b1);
    check("ff_out_valid", 128'(bus.out_valid), 128'(1));
    check("ff_act_word0", bus.act_word, C0);
    check("ff_sp_word0", bus.sp_word, C0 ^ SPX);
    check("ff_addr0", 128'(bus.word_addr), 128'(0));
    check("ff_done0", 128'(bus.layer_done), 128'(0));
    repeat (4) step(1'b1, 1'b1);
    check("ff_addr1", 128'(bus.word_addr), 128'(1));
    check("ff_done1", 128'(bus.layer_done), 128'(1));
    step(1'b0, 1'b1);
    check("ff_drained", 128'(bus.out_valid), 128'(0));
    // backpressure and simultaneous drain/complete
    for (int k = 0; k < 13; k++) begin
      step(bp[k].v, bp[k].r);
      check($sformatf("bp%0d_in_ready", k), 128'(rdy_s), 128'(bp[k].exp_rdy));
      check($sformatf("bp%0d_out_valid", k), 128'(ov_s), 128'(bp[k].exp_ov));
    end
    // gapped input
    s = 16;
    for (int k = 0; k < 7; k++) step(k % 2 == 0, 1'b1);
    check("gap_out_valid", 128'(bus.out_valid), 128'(1));
    check("gap_act_word", bus.act_word, C0);
    check("gap_addr", 128'(bus.word_addr), 128'(0));
    step(1'b0, 1'b1);
    // mid-word reset
    s = 4;
    repeat (2) step(1'b1, 1'b1);
    reset_n = 1'b0;
    step(1'b0, 1'b1);
    reset_n = 1'b1;
    check("mr_out_valid", 128'(bus.out_valid), 128'(0));
    check("mr_in_ready", 128'(bus.in_ready), 128'(1));
    check("mr_word_addr", 128'(bus.word_addr), 128'(0));
    s = 0;
    repeat (4) step(1'b1, 1'b1);
    check("mr_out_valid_word", 128'(bus.out_valid), 128'(1));
    check("mr_act_word", bus.act_word, C0);
    check("mr_addr", 128'(bus.word_addr), 128'(0));
    step(1'b0, 1'b1);
    // three-layer wrap
    reset_n = 1'b0;
    step(1'b0, 1'b0);
    reset_n = 1'b1;
    p0 = n_pop;
    d0 = n_done;
    s = 0;
    repeat (24) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("wrap_words", 128'(n_pop - p0), 128'(6));
    check("wrap_layer_done", 128'(n_done - d0), 128'(3));
    check("sb_leftover", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
